image_scan_controller: RTL and testbench
========================================

// Module: image_scan_controller
// PURPOSE
//  Sequences the image ROM container: raster-scans pixel addresses 0..FRAME_WIDTH*FRAME_HEIGHT-1,
//  issues one single-cycle read enable per pixel, waits for the container's pixel-valid pulse,
//  and forwards each pixel downstream on a valid/ready handshake with row/col tags.
//  Sits between the test image store and the face-detection front end (integral image / window buffer).
// PARAMETERS
//  DATA_WIDTH_8    8    pixel width
//  DATA_WIDTH_16   16   coordinate index / row / col width
//  FRAME_WIDTH     160  pixels per row (>=1)
//  FRAME_HEIGHT    120  rows per frame (>=1); FRAME_WIDTH*FRAME_HEIGHT <= 2**DATA_WIDTH_16
//  WAIT_TIMEOUT    15   max cycles in WAIT before error abort (>=3)
// PORTS
//  clk                clk  in   1   single clock, all logic posedge
//  reset              in   1   asynchronous, active-low reset (asserted when 0)
//  i_start            in   1   pulse: begin frame scan (ignored unless IDLE/DONE)
//  i_abort            in   1   synchronous abort: back to IDLE next cycle
//  o_img_enable       out  1   read enable to image container, one-cycle pulse per pixel
//  o_coordinate_index out  16  ROM address, stable from ISSUE through end of WAIT
//  i_img_pixel        in   8   pixel data from container
//  i_img_pixel_valid  in   1   container pixel-ready pulse (arrives 2 cycles after enable)
//  o_pixel            out  8   held pixel to downstream
//  o_pixel_valid      out  1   downstream valid
//  i_pixel_ready      in   1   downstream ready
//  o_row / o_col      out  16  coordinates of pixel on o_pixel
//  o_busy             out  1   high in ISSUE/WAIT/PRESENT
//  o_frame_done       out  1   one-cycle pulse after last pixel handshake
//  o_error            out  1   sticky: WAIT timeout occurred; cleared by i_start or reset
// BEHAVIOUR
//  Reset (reset=0): state IDLE; every output 0; index/row/col counters 0; holding register 0.
//  States: IDLE, ISSUE, WAIT, PRESENT, DONE.
//   IDLE:    i_start -> ISSUE; index=0,row=0,col=0; o_error cleared.
//   ISSUE:   o_img_enable=1 for exactly this cycle -> WAIT; wait counter cleared.
//   WAIT:    on i_img_pixel_valid capture i_img_pixel -> PRESENT. Wait counter increments;
//            reaching WAIT_TIMEOUT with no valid -> set o_error, -> IDLE (no frame_done).
//   PRESENT: o_pixel_valid=1, o_pixel/o_row/o_col stable until i_pixel_ready sampled high.
//            Handshake on last pixel (index=W*H-1) -> DONE; else advance and -> ISSUE.
//   DONE:    o_frame_done=1 this cycle only; -> IDLE (i_start here starts new frame at 0).
//  Advance: col+1; col==FRAME_WIDTH-1 wraps to 0 with row+1; index+1 (never wraps mid-frame).
//  Throughput: 4 cycles/pixel with i_pixel_ready held high (ISSUE,WAIT x2,PRESENT).
//  Only one read outstanding; i_img_pixel_valid outside WAIT is ignored (no capture).
//  i_start while busy ignored. i_abort has priority over all transitions incl. handshake:
//   -> IDLE next cycle, o_pixel_valid/o_img_enable drop, no frame_done, o_error unchanged.
//  Simultaneous valid and timeout in same WAIT cycle: valid wins.
//  Async reset mid-frame: immediate return to reset values; next frame restarts at index 0.
//  1x1 frame: ISSUE,WAIT,PRESENT,DONE then IDLE.
// STRUCTURE
//  Shared package/header: state encodings (3-bit localparams), DATA_WIDTH_* constants.
//  One sub-module: raster_counter (col/row/index counters with advance, clear, last flag).
//  Controller FSM and pixel holding register in this module; image container instantiated by bench/top.
// TESTING
//  Bench instantiates image_container with 4x2 MIF (pixels 0x10..0x17), FRAME_WIDTH=4,FRAME_HEIGHT=2.
//  1 Full frame, ready=1: start -> 8 pixels 0x10..0x17, row/col (0,0)..(1,3), one frame_done, 32 cycles.
//  2 Backpressure: ready low 5 cycles on pixel 3 -> o_pixel=0x13 held stable, no extra enable, order intact.
//  3 Timeout: stub never returns valid -> o_error=1 after 15 WAIT cycles, IDLE, no frame_done; start clears.
//  4 Abort at pixel 5 in PRESENT -> IDLE next cycle, valid=0; restart delivers 0x10 at (0,0).
//  5 Async reset (reset=0) mid-WAIT -> all outputs 0 immediately; start after release scans from 0.
//  6 Start ignored while busy; start in DONE cycle -> second frame begins, two frame_done pulses total.

Source files
------------

// File: rtl/image_scan_controller_pkg.sv
// Shared encodings and width defaults for the image scan controller and its raster counter.
package image_scan_controller_pkg;

  localparam int DATA_WIDTH_8_DEF  = 8;
  localparam int DATA_WIDTH_16_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } scan_state_e;

  function automatic logic is_busy(input scan_state_e s);
    return (s == ST_ISSUE) || (s == ST_WAIT) || (s == ST_PRESENT);
  endfunction

endpackage

// File: rtl/image_scan_controller_raster_counter.sv
// Column/row/linear-index counters for a raster scan, with synchronous clear,
// single-step advance and a flag marking the last pixel of the frame.
module raster_counter
  import image_scan_controller_pkg::*;
#(
  parameter int FRAME_WIDTH  = 160,
  parameter int FRAME_HEIGHT = 120,
  parameter int IDX_W        = DATA_WIDTH_16_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             adv,
  output logic [IDX_W-1:0] col,
  output logic [IDX_W-1:0] row,
  output logic [IDX_W-1:0] index,
  output logic             last
);

  localparam logic [IDX_W-1:0] COL_MAX  = IDX_W'(FRAME_WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WIDTH * FRAME_HEIGHT - 1);

  logic [IDX_W-1:0] col_q, col_d;
  logic [IDX_W-1:0] row_q, row_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    idx_d = idx_q;
    if (clr) begin
      col_d = '0;
      row_d = '0;
      idx_d = '0;
    end else if (adv) begin
      idx_d = idx_q + 1'b1;
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
      idx_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      idx_q <= idx_d;
    end
  end

  assign col   = col_q;
  assign row   = row_q;
  assign index = idx_q;
  assign last  = (idx_q == LAST_IDX);

endmodule

// File: rtl/image_scan_controller.sv
// Raster-scans the image ROM one read at a time and forwards each pixel downstream
// on a valid/ready handshake tagged with its row/col, with timeout and abort handling.
module image_scan_controller
  import image_scan_controller_pkg::*;
#(
  parameter int DATA_WIDTH_8  = DATA_WIDTH_8_DEF,
  parameter int DATA_WIDTH_16 = DATA_WIDTH_16_DEF,
  parameter int FRAME_WIDTH   = 160,
  parameter int FRAME_HEIGHT  = 120,
  parameter int WAIT_TIMEOUT  = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic                     i_abort,
  output logic                     o_img_enable,
  output logic [DATA_WIDTH_16-1:0] o_coordinate_index,
  input  logic [DATA_WIDTH_8-1:0]  i_img_pixel,
  input  logic                     i_img_pixel_valid,
  output logic [DATA_WIDTH_8-1:0]  o_pixel,
  output logic                     o_pixel_valid,
  input  logic                     i_pixel_ready,
  output logic [DATA_WIDTH_16-1:0] o_row,
  output logic [DATA_WIDTH_16-1:0] o_col,
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic                     o_error
);

  localparam int WCNT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_TIMEOUT - 1);

  scan_state_e             state_q, state_d;
  logic [WCNT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [DATA_WIDTH_8-1:0] pixel_q, pixel_d;
  logic                    error_q, error_d;
  logic                    enable_q, enable_d;
  logic                    pvalid_q, pvalid_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    cnt_clr, cnt_adv, cnt_last;

  raster_counter #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .FRAME_HEIGHT(FRAME_HEIGHT),
    .IDX_W       (DATA_WIDTH_16)
  ) u_raster (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .adv  (cnt_adv),
    .col  (o_col),
    .row  (o_row),
    .index(o_coordinate_index),
    .last (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pixel_d    = pixel_q;
    error_d    = error_q;
    cnt_clr    = 1'b0;
    cnt_adv    = 1'b0;
    if (i_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (i_start) begin
            state_d = ST_ISSUE;
            cnt_clr = 1'b1;
            error_d = 1'b0;
          end
        end
        ST_ISSUE: begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end
        // A pixel arriving on the timeout cycle still counts as delivered.
        ST_WAIT: begin
          if (i_img_pixel_valid) begin
            pixel_d = i_img_pixel;
            state_d = ST_PRESENT;
          end else if (wait_cnt_q == WCNT_LAST) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
        ST_PRESENT: begin
          if (i_pixel_ready) begin
            if (cnt_last) begin
              state_d = ST_DONE;
            end else begin
              cnt_adv = 1'b1;
              state_d = ST_ISSUE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Outputs are decoded from the next state so they come straight off flops.
    enable_d = (state_d == ST_ISSUE);
    pvalid_d = (state_d == ST_PRESENT);
    done_d   = (state_d == ST_DONE);
    busy_d   = is_busy(state_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      pixel_q    <= '0;
      error_q    <= 1'b0;
      enable_q   <= 1'b0;
      pvalid_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      pixel_q    <= pixel_d;
      error_q    <= error_d;
      enable_q   <= enable_d;
      pvalid_q   <= pvalid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign o_img_enable  = enable_q;
  assign o_pixel       = pixel_q;
  assign o_pixel_valid = pvalid_q;
  assign o_busy        = busy_q;
  assign o_frame_done  = done_q;
  assign o_error       = error_q;

endmodule

// File: tb/tb_image_scan_controller.sv
// Bench for image_scan_controller on a 4x2 frame with a behavioural image container
// (pixel i = 0x10+i, valid two cycles after enable) and a frame-level reference model.
module tb_image_scan_controller;

  localparam int FW = 4;
  localparam int FH = 2;
  localparam int NPIX = FW * FH;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic        o_img_enable;
  logic [15:0] o_coordinate_index;
  logic [7:0]  img_pixel;
  logic        img_valid;
  logic [7:0]  o_pixel;
  logic        o_pixel_valid;
  logic        i_pixel_ready = 1'b1;
  logic [15:0] o_row;
  logic [15:0] o_col;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_error;

  int checks = 0;
  int errors = 0;
  bit mute = 1'b0;
  logic [7:0] mem [NPIX];
  logic en_d1;

  image_scan_controller #(
    .DATA_WIDTH_8 (8),
    .DATA_WIDTH_16(16),
    .FRAME_WIDTH  (FW),
    .FRAME_HEIGHT (FH),
    .WAIT_TIMEOUT (15)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .i_start           (i_start),
    .i_abort           (i_abort),
    .o_img_enable      (o_img_enable),
    .o_coordinate_index(o_coordinate_index),
    .i_img_pixel       (img_pixel),
    .i_img_pixel_valid (img_valid),
    .o_pixel           (o_pixel),
    .o_pixel_valid     (o_pixel_valid),
    .i_pixel_ready     (i_pixel_ready),
    .o_row             (o_row),
    .o_col             (o_col),
    .o_busy            (o_busy),
    .o_frame_done      (o_frame_done),
    .o_error           (o_error)
  );

  always #5 clk = ~clk;

  // Image container: data and valid appear two cycles after the enable pulse.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_d1     <= 1'b0;
      img_valid <= 1'b0;
      img_pixel <= 8'h00;
    end else begin
      en_d1     <= o_img_enable;
      img_valid <= en_d1 && !mute;
      if (en_d1) img_pixel <= mem[o_coordinate_index[2:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_enable"}, 32'(o_img_enable), 0);
    check({tag, "_valid"},  32'(o_pixel_valid), 0);
    check({tag, "_busy"},   32'(o_busy), 0);
    check({tag, "_done"},   32'(o_frame_done), 0);
  endtask

  // Frame-level reference: pixel k must be 0x10+k at (k/FW, k%FW), in order, once each.
  task automatic run_frame(input int stall_pix, input int stall_len, input bit rnd,
                           input bit poke, input bit restart, input int abort_at,
                           output int cyc);
    int k = 0;
    int en = 0;
    int dn = 0;
    int stalled = 0;
    bit fin = 1'b0;
    cyc = 0;
    while (!fin && cyc < 1000) begin
      cyc++;
      if (o_img_enable) en++;
      if (o_frame_done) dn++;
      if (o_pixel_valid) begin
        check("pixel", 32'(o_pixel), 32'h10 + 32'(k));
        check("row", 32'(o_row), 32'(k / FW));
        check("col", 32'(o_col), 32'(k % FW));
        if (k == abort_at) begin
          i_abort = 1'b1;
          step();
          i_abort = 1'b0;
          check_idle_outputs("abort");
          for (int j = 0; j < 3; j++) begin
            step();
            check("abort_no_done", 32'(o_frame_done | o_busy), 0);
          end
          fin = 1'b1;
        end
      end
      if (!fin) begin
        if (o_frame_done) begin
          fin = 1'b1;
          if (restart) pulse_start();
        end else begin
          if (rnd) i_pixel_ready = 1'($urandom_range(0, 1));
          else if (o_pixel_valid && k == stall_pix && stalled < stall_len) begin
            i_pixel_ready = 1'b0;
            stalled++;
          end else i_pixel_ready = 1'b1;
          if (o_pixel_valid && i_pixel_ready) k++;
          i_start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
          step();
        end
      end
    end
    i_start = 1'b0;
    i_pixel_ready = 1'b1;
    if (!fin) check("frame_timeout", 0, 1);
    if (abort_at < 0) begin
      check("pix_count", 32'(k), NPIX);
      check("enables", 32'(en), NPIX);
      check("frame_done_pulses", 32'(dn), 1);
    end
  endtask

  initial begin
    int cyc;
    int dn;
    int en;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(8'h10 + i);

    // Reset state
    #12;
    check_idle_outputs("rst");
    check("rst_index", 32'(o_coordinate_index), 0);
    check("rst_pixel", 32'(o_pixel), 0);
    check("rst_rowcol", 32'({o_row, o_col}), 0);
    check("rst_error", 32'(o_error), 0);
    reset = 1'b1;
    step();

    // Full frame with ready held high
    pulse_start();
    check("issue_enable", 32'(o_img_enable), 1);
    check("issue_busy", 32'(o_busy), 1);
    run_frame(-1, 0, 1'b0, 1'b0, 1'b0, -1, cyc);
    check("frame_cycles", 32'(cyc), 33);
    step();
    check("after_done_idle", 32'(o_busy | o_frame_done), 0);

    // Backpressure on pixel 3
    pulse_start();
    run_frame(3, 5, 1'b0, 1'b0, 1'b0, -1, cyc);
    check("stall_cycles", 32'(cyc), 38);
    step();

    // Timeout: container never answers
    mute = 1'b1;
    pulse_start();
    cyc = 1;
    dn = 0;
    en = 0;
    while (o_busy && cyc < 100) begin
      if (o_img_enable) en++;
      step();
      cyc++;
      if (o_frame_done) dn++;
    end
    check("timeout_cycles", 32'(cyc), 17);
    check("timeout_error", 32'(o_error), 1);
    check("timeout_enables", 32'(en), 1);
    check("timeout_no_done", 32'(dn), 0);
    step();
    check("error_sticky", 32'(o_error), 1);
    mute = 1'b0;
    pulse_start();
    check("start_clears_error", 32'(o_error), 0);
    run_frame(-1, 0, 1'b0, 1'b0, 1'b0, -1, cyc);
    step();

    // Abort while presenting pixel 5, then restart from pixel 0
    pulse_start();
    run_frame(-1, 0, 1'b0, 1'b0, 1'b0, 5, cyc);
    check("abort_error_kept", 32'(o_error), 0);
    pulse_start();
    run_frame(-1, 0, 1'b0, 1'b0, 1'b0, -1, cyc);
    step();

    // Asynchronous reset while waiting on pixel 2
    pulse_start();
    for (int j = 0; j < 9; j++) step();
    check("prereset_index", 32'(o_coordinate_index), 2);
    check("prereset_busy", 32'(o_busy), 1);
    reset = 1'b0;
    #1;
    check_idle_outputs("arst");
    check("arst_index", 32'(o_coordinate_index), 0);
    check("arst_rowcol", 32'({o_row, o_col}), 0);
    @(negedge clk);
    reset = 1'b1;
    step();
    pulse_start();
    run_frame(-1, 0, 1'b0, 1'b0, 1'b0, -1, cyc);
    step();

    // Start pulses while busy are ignored; start in DONE chains a second frame
    pulse_start();
    run_frame(-1, 0, 1'b0, 1'b1, 1'b1, -1, cyc);
    check("chain_issue", 32'(o_img_enable), 1);
    run_frame(-1, 0, 1'b0, 1'b0, 1'b0, -1, cyc);
    check("chain_cycles", 32'(cyc), 33);
    step();

    // Random downstream backpressure
    for (int f = 0; f < 3; f++) begin
      pulse_start();
      run_frame(-1, 0, 1'b1, 1'b0, 1'b0, -1, cyc);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
